// File: rtl/ibex_shadow_stack_ring.sv
// ----------------------------------------------------------------------------
// ibex_shadow_stack_ring
//
// Circular return-address shadow stack. Call retirement pushes the return
// address; return retirement compares the actual target against the top
// entry and pops it. Supports push+pop in the same cycle (top replacement),
// an optional overwrite-oldest policy when full, a registered one-cycle
// error pulse with code, and sticky status bits cleared by software.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   en_i         block enable (gates push_i/pop_i only)
//   push_i       call retired, store push_data_i
//   push_data_i  return address to save
//   pop_i        return retired, compare pop_data_i against top
//   pop_data_i   actual return target
//   clr_i        clears sticky status
//   flush_i      empties the stack
//   top_o        current top entry (0 when empty)
//   count_o      occupancy
//   err_o        one-cycle registered error pulse
//   err_code_o   0 none, 1 mismatch, 2 overflow, 3 underflow
//   status_o     sticky {underflow, overflow, mismatch}
// ----------------------------------------------------------------------------
module ibex_shadow_stack_ring #(
    parameter int          DataWidth  = 32,
    parameter int          Depth      = 16,
    parameter logic        WrapOnFull = 1'b0,
    localparam int         CntW       = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] push_data_i,
    input  logic                 pop_i,
    input  logic [DataWidth-1:0] pop_data_i,
    input  logic                 clr_i,
    input  logic                 flush_i,
    output logic [DataWidth-1:0] top_o,
    output logic [CntW-1:0]      count_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o,
    output logic [2:0]           status_o
);

    localparam int HeadW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [HeadW-1:0] LastIdx = HeadW'(Depth - 1);
    localparam logic [CntW-1:0]  FullCnt = CntW'(Depth);

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_MISMATCH  = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_UNDERFLOW = 2'd3
    } err_code_e;

    logic [DataWidth-1:0] mem [Depth];

    logic [HeadW-1:0] head, head_n;
    logic [CntW-1:0]  count, count_n;
    logic             lost, lost_n;
    logic             err, err_n;
    err_code_e        err_code, err_code_n;
    logic [2:0]       status, status_n;

    logic [HeadW-1:0]     head_inc;
    logic [HeadW-1:0]     head_dec;
    logic [DataWidth-1:0] top_entry;
    logic                 empty;
    logic                 full;
    logic                 mem_we;
    logic [HeadW-1:0]     mem_waddr;

    // Head wraps by explicit compare so non-power-of-two depths work.
    assign head_inc  = (head == LastIdx) ? '0 : head + 1'b1;
    assign head_dec  = (head == '0) ? LastIdx : head - 1'b1;
    assign top_entry = mem[head_dec];
    assign empty     = (count == '0);
    assign full      = (count == FullCnt);

    assign top_o      = empty ? '0 : top_entry;
    assign count_o    = count;
    assign err_o      = err;
    assign err_code_o = err_code;
    assign status_o   = status;

    always_comb begin
        count_n    = count;
        head_n     = head;
        lost_n     = lost;
        err_n      = 1'b0;
        err_code_n = ERR_NONE;
        mem_we     = 1'b0;
        mem_waddr  = head;

        if (flush_i) begin
            count_n = '0;
            head_n  = '0;
            lost_n  = 1'b0;
        end else if (en_i) begin
            if (push_i && pop_i) begin
                if (!empty) begin
                    // Swap: check the return, then replace the top in place.
                    if (top_entry != pop_data_i) begin
                        err_n      = 1'b1;
                        err_code_n = ERR_MISMATCH;
                    end
                    mem_we    = 1'b1;
                    mem_waddr = head_dec;
                end else begin
                    // Pop on empty followed by an ordinary push.
                    if (!lost) begin
                        err_n      = 1'b1;
                        err_code_n = ERR_UNDERFLOW;
                    end
                    mem_we  = 1'b1;
                    head_n  = head_inc;
                    count_n = CntW'(1);
                end
            end else if (push_i) begin
                if (!full) begin
                    mem_we  = 1'b1;
                    head_n  = head_inc;
                    count_n = count + CntW'(1);
                end else if (WrapOnFull) begin
                    // When full, head points at the oldest entry.
                    mem_we = 1'b1;
                    head_n = head_inc;
                    lost_n = 1'b1;
                end else begin
                    err_n      = 1'b1;
                    err_code_n = ERR_OVERFLOW;
                end
            end else if (pop_i) begin
                if (!empty) begin
                    if (top_entry != pop_data_i) begin
                        err_n      = 1'b1;
                        err_code_n = ERR_MISMATCH;
                    end
                    head_n  = head_dec;
                    count_n = count - CntW'(1);
                end else if (!lost) begin
                    err_n      = 1'b1;
                    err_code_n = ERR_UNDERFLOW;
                end
            end
        end

        // A new error's bit wins over a coincident clear.
        status_n = clr_i ? 3'b000 : status;
        case (err_code_n)
            ERR_MISMATCH:  status_n[0] = 1'b1;
            ERR_OVERFLOW:  status_n[1] = 1'b1;
            ERR_UNDERFLOW: status_n[2] = 1'b1;
            default:       ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count    <= '0;
            head     <= '0;
            lost     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            status   <= 3'b000;
        end else begin
            count    <= count_n;
            head     <= head_n;
            lost     <= lost_n;
            err      <= err_n;
            err_code <= err_code_n;
            status   <= status_n;
        end
    end

    // Storage is deliberately not reset; writes are dropped during reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we) begin
            mem[mem_waddr] <= push_data_i;
        end
    end

endmodule

// File: doc/ibex_shadow_stack_ring.md
Name: ibex_shadow_stack_ring

Overview:
Parametrised successor to the core's single-port shadow stack: a return-address stack that records call targets and checks returns against them. Storage is circular, so depth, width and full-stack policy are all configurable. Adds simultaneous push+pop (tail-call/co-routine swap), an optional overwrite-oldest mode, a registered error code and sticky status with software clear. Sits beside the ID/EX stage and is fed by the call/return decode strobes.

Parameters:
DataWidth, 32, width of stored pointers
Depth, 16, number of entries (≥2, any integer, not restricted to power of two)
WrapOnFull, 1'b0, 0: push when full is rejected and flagged overflow; 1: push overwrites the oldest entry silently
CntW, $clog2(Depth+1), derived width of the occupancy count (localparam)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
en_i  in  1  block enable; when 0, push_i/pop_i are ignored and no errors are raised
push_i  in  1  call retired; store push_data_i
push_data_i  in  DataWidth  return address to save
pop_i  in  1  return retired; compare pop_data_i against top
pop_data_i  in  DataWidth  actual return target
clr_i  in  1  clears sticky status bits
flush_i  in  1  empties stack (context switch)
top_o  out  DataWidth  current top entry (0 when empty)
count_o  out  CntW  occupancy
err_o  out  1  one-cycle error pulse, registered
err_code_o  out  2  0 none, 1 mismatch, 2 overflow, 3 underflow; valid with err_o
status_o  out  3  sticky {underflow, overflow, mismatch}

Behaviour:
- Reset (rst_i high at posedge): count=0, head=0, lost=0, err_o=0, err_code_o=0, status_o=0; storage contents are not reset; top_o=0 (masked when empty).
- Storage: Depth×DataWidth array with head index pointing at the next free slot. Head wraps Depth-1→0 and 0→Depth-1 by explicit compare, not by modulo arithmetic.
- Push only (en_i & push_i & !pop_i):
  - count<Depth: write at head, head+1, count+1.
  - count==Depth, WrapOnFull=0: no write, no state change, overflow error.
  - count==Depth, WrapOnFull=1: write at head (this slot holds the oldest entry), head+1, count unchanged, lost←1, no error.
- Pop only (en_i & pop_i & !push_i):
  - count>0: compare top against pop_data_i; head-1, count-1; mismatch error if unequal.
  - count==0 & lost=0: underflow error.
  - count==0 & lost=1: no error, no change (check not possible after dropped entries).
- Push+pop same cycle:
  - count>0: compare top against pop_data_i, overwrite the top slot with push_data_i; head and count unchanged.
  - count==0: treated as pop on empty (underflow unless lost), followed by a normal push; count becomes 1.
- Error latency: err_o/err_code_o registered, asserted the cycle after the offending strobe, held for exactly one cycle. Only one code per event; priority is underflow > overflow > mismatch.
- Sticky status: the bit for err_code_o sets in the same cycle err_o asserts. Bits clear only on clr_i or reset. If clr_i coincides with a new error, the new error's bit wins (set).
- flush_i: count=0, head=0, lost=0 next cycle, with priority over push/pop that cycle and no errors raised; status_o is preserved.
- en_i=0: strobes are ignored entirely. flush_i and clr_i still act.
- Reset mid-operation: a strobe in the reset cycle is discarded; any pending err_o is cleared.
- lost clears when count returns to 0 via flush or reset only.
- Comparison is full DataWidth, bitwise equality.

Test Plan:
- Reset, push 0x100,0x200,0x300, pop 0x300,0x200,0x100 -> count 3→0, top_o tracks 0x300/0x200/0x100, err_o never asserts.
- Depth=4, WrapOnFull=0: 5 pushes -> 5th rejected, cycle after: err_o=1, err_code_o=2, status_o=3'b010, count_o=4, top_o unchanged.
- Depth=4, WrapOnFull=1: push 1..6, pop 6,5,4,3 then pop 0xDEAD -> all matches, count 0, final pop raises no error, status_o=0.
- Push 0xA0, pop 0xA4 -> err_code_o=1 for one cycle, count 0; next cycle clr_i -> status_o=0.
- Push 0x10, then push 0x20+pop 0x10 same cycle -> no error, count 1, top_o=0x20; then push+pop with empty stack after flush_i -> err_code_o=3, count 1.
- en_i=0 with push_i/pop_i toggling for 10 cycles -> count/status unchanged. Pop on empty while rst_i high -> no err_o.
